// File: rtl/band_sum_sequencer.sv
// band_sum_sequencer: collects one signed sample per equalizer band through
// independent valid/ready handshakes. It then sums them one band per cycle
// through a single shared sign-extending adder, and presents the frame sum
// downstream over a valid/ready handshake. Bands may be muted by a mask that
// is snapshotted when collection completes.
module band_sum_sequencer #(
    parameter int NBANDS = 8,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBANDS-1:0]        band_valid,
    input  logic [NBANDS*DATA_W-1:0] band_data,
    output logic [NBANDS-1:0]        band_ready,
    input  logic [NBANDS-1:0]        band_mask,
    output logic [ACC_W-1:0]         sum_data,
    output logic                     sum_valid,
    input  logic                     sum_ready,
    output logic                     busy
);

    localparam int IDX_W = (NBANDS > 1) ? $clog2(NBANDS) : 1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    // Replicate the sample MSB into the upper accumulator bits.
    function automatic logic [ACC_W-1:0] sext(input logic [DATA_W-1:0] s);
        return {{(ACC_W-DATA_W){s[DATA_W-1]}}, s};
    endfunction

    state_t              state_r;
    state_t              state_s;
    logic [NBANDS-1:0]   pending_r;
    logic [NBANDS-1:0]   pending_s;
    logic [NBANDS-1:0]   capture_s;
    logic [DATA_W-1:0]   samples_r [NBANDS];
    logic [NBANDS-1:0]   mask_snap_r;
    logic                start_s;
    logic                finish_s;
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    idx_s;
    logic [ACC_W-1:0]    acc_r;
    logic [ACC_W-1:0]    acc_s;
    logic [ACC_W-1:0]    addend_s;
    logic [DATA_W-1:0]   sample_s;
    logic [NBANDS-1:0]   band_ready_r;
    logic                sum_valid_r;
    logic [ACC_W-1:0]    sum_data_r;
    logic                busy_r;

    assign band_ready = band_ready_r;
    assign sum_valid  = sum_valid_r;
    assign sum_data   = sum_data_r;
    assign busy       = busy_r;

    // Select the addend for the band currently being accumulated; muted bands add zero.
    always_comb begin
        sample_s = samples_r[idx_r];
        if (mask_snap_r[idx_r]) begin
            addend_s = sext(sample_s);
        end else begin
            addend_s = {ACC_W{1'b0}};
        end
    end

    // Next-state logic: capture in COLLECT, one add per cycle in ACCUM, hold in OUTPUT.
    always_comb begin
        state_s   = state_r;
        pending_s = pending_r;
        capture_s = {NBANDS{1'b0}};
        acc_s     = acc_r;
        idx_s     = idx_r;
        start_s   = 1'b0;
        finish_s  = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                capture_s = band_valid & band_ready_r;
                pending_s = pending_r | capture_s;
                // Muted bands count as done so an all-muted frame starts at once.
                if (&(pending_r | ~band_mask)) begin
                    state_s = ST_ACCUM;
                    start_s = 1'b1;
                    acc_s   = {ACC_W{1'b0}};
                    idx_s   = {IDX_W{1'b0}};
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_ACCUM: begin
                acc_s = acc_r + addend_s;
                idx_s = idx_r + IDX_W'(1);
                if (idx_r == IDX_W'(NBANDS-1)) begin
                    state_s  = ST_OUTPUT;
                    finish_s = 1'b1;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_OUTPUT: begin
                if (sum_ready) begin
                    state_s   = ST_COLLECT;
                    pending_s = {NBANDS{1'b0}};
                end else begin
                    state_s = ST_OUTPUT;
                end
            end
            default: begin
                state_s   = ST_COLLECT;
                pending_s = {NBANDS{1'b0}};
            end
        endcase
    end

    // State, pending flags, index and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_COLLECT;
            pending_r <= {NBANDS{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
            acc_r     <= {ACC_W{1'b0}};
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            idx_r     <= idx_s;
            acc_r     <= acc_s;
        end
    end

    // Sample capture storage and the mask snapshot taken when collection completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBANDS; i++) begin
                samples_r[i] <= {DATA_W{1'b0}};
            end
            mask_snap_r <= {NBANDS{1'b0}};
        end else begin
            for (int i = 0; i < NBANDS; i++) begin
                if (capture_s[i]) begin
                    samples_r[i] <= band_data[i*DATA_W +: DATA_W];
                end
            end
            if (start_s) begin
                mask_snap_r <= band_mask;
            end
        end
    end

    // Registered outputs, decoded from the upcoming state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            band_ready_r <= {NBANDS{1'b0}};
            sum_valid_r  <= 1'b0;
            sum_data_r   <= {ACC_W{1'b0}};
            busy_r       <= 1'b0;
        end else begin
            band_ready_r <= (state_s == ST_COLLECT) ? ~pending_s : {NBANDS{1'b0}};
            sum_valid_r  <= (state_s == ST_OUTPUT);
            busy_r       <= (state_s != ST_COLLECT);
            if (finish_s) begin
                sum_data_r <= acc_s;
            end
        end
    end

endmodule

// File: tb/tb_band_sum_sequencer.sv
// Testbench for band_sum_sequencer: directed frames checked against a
// frame-level model plus hand-computed literal sums and latencies.
module tb_band_sum_sequencer;

    localparam int NB = 8;
    localparam int DW = 16;
    localparam int AW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [NB-1:0]  band_valid;
    logic [NB*DW-1:0] band_data;
    logic [NB-1:0]  band_ready;
    logic [NB-1:0]  band_mask;
    logic [AW-1:0]  sum_data;
    logic           sum_valid;
    logic           sum_ready;
    logic           busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    band_sum_sequencer #(.NBANDS(NB), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .band_valid (band_valid),
        .band_data  (band_data),
        .band_ready (band_ready),
        .band_mask  (band_mask),
        .sum_data   (sum_data),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // ---------------- frame-level model ----------------
    // m_cd: -1 while collecting, N..1 cycles of summing left, 0 = sum presented.
    logic                 m_armed;
    int                   m_cd;
    logic [NB-1:0]        m_pend;
    logic signed [DW-1:0] m_vals [NB];
    logic [AW-1:0]        m_exp;

    wire [NB-1:0] m_ready = (m_armed && m_cd == -1) ? ~m_pend : 8'h00;
    wire [NB-1:0] m_cap   = band_valid & m_ready;
    wire          m_done  = &(m_pend | ~band_mask);

    function automatic logic [AW-1:0] frame_sum();
        int s;
        logic signed [DW-1:0] v;
        s = 0;
        for (int i = 0; i < NB; i++) begin
            v = m_cap[i] ? band_data[i*DW +: DW] : m_vals[i];
            if (band_mask[i]) s += v;
        end
        return 32'(s);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_armed <= 1'b0;
            m_cd    <= -1;
            m_pend  <= 8'h00;
            m_exp   <= 32'h0;
            for (int i = 0; i < NB; i++) m_vals[i] <= 16'sh0;
        end else begin
            m_armed <= 1'b1;
            if (m_cd == -1) begin
                for (int i = 0; i < NB; i++) begin
                    if (m_cap[i]) m_vals[i] <= band_data[i*DW +: DW];
                end
                m_pend <= m_pend | m_cap;
                if (m_done) begin
                    m_exp <= frame_sum();
                    m_cd  <= NB;
                end
            end else if (m_cd > 0) begin
                m_cd <= m_cd - 1;
            end else if (sum_ready) begin
                m_cd   <= -1;
                m_pend <= 8'h00;
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        check("band_ready", {24'h0, band_ready}, {24'h0, m_ready});
        check("sum_valid", {31'h0, sum_valid}, {31'h0, (m_cd == 0)});
        check("busy", {31'h0, busy}, {31'h0, (m_cd != -1)});
        if (rst) check("sum_data_in_reset", sum_data, 32'h0);
        else if (m_cd == 0) check("sum_data", sum_data, m_exp);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sum(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!sum_valid && n < 40);
        if (!sum_valid) check("sum_timeout", {31'h0, sum_valid}, 32'd1);
    endtask

    task automatic set_all(input logic [DW-1:0] v);
        for (int i = 0; i < NB; i++) band_data[i*DW +: DW] = v;
    endtask

    int n;
    int seen;

    initial begin
        band_valid = 8'h00;
        band_mask  = 8'hFF;
        band_data  = '0;
        sum_ready  = 1'b1;
        rst        = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_band_ready", {24'h0, band_ready}, 32'h0);
        check("rst_sum_valid", {31'h0, sum_valid}, 32'h0);
        check("rst_sum_data", sum_data, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("ready_after_reset", {24'h0, band_ready}, 32'h0000_00FF);

        // 1: all bands at once, values 1..8
        for (int i = 0; i < NB; i++) band_data[i*DW +: DW] = 16'(i + 1);
        band_valid = 8'hFF;
        tick();
        band_valid = 8'h00;
        wait_sum(n);
        check("t1_latency", 32'(n), 32'd9);
        check("t1_sum", sum_data, 32'd36);
        check("t1_model_sum", m_exp, 32'd36);
        tick();
        check("t1_valid_one_cycle", {31'h0, sum_valid}, 32'h0);
        check("t1_ready_back", {24'h0, band_ready}, 32'h0000_00FF);

        // 2: staggered arrivals of -32768
        set_all(16'h8000);
        for (int c = 0; c < 3 * NB - 2; c++) begin
            band_valid = 8'h00;
            for (int i = 0; i < NB; i++) if (3 * i == c) band_valid[i] = 1'b1;
            tick();
        end
        band_valid = 8'h00;
        check("t2_all_pending", {24'h0, band_ready}, 32'h0);
        wait_sum(n);
        check("t2_latency", 32'(n), 32'd9);
        check("t2_sum", sum_data, 32'hFFFC_0000);
        tick();

        // 3: mask 0F, mask change during summing has no effect
        set_all(16'd100);
        band_mask  = 8'h0F;
        band_valid = 8'hFF;
        tick();
        band_valid = 8'h00;
        tick();
        tick();
        band_mask = 8'hFF;
        wait_sum(n);
        check("t3_latency", 32'(n), 32'd7);
        check("t3_sum_masked", sum_data, 32'd400);
        tick();
        band_valid = 8'hFF;
        tick();
        band_valid = 8'h00;
        wait_sum(n);
        check("t3_sum_full", sum_data, 32'd800);
        tick();

        // 4: backpressure, values -3000..4000 step 1000
        for (int i = 0; i < NB; i++) band_data[i*DW +: DW] = 16'(i * 1000 - 3000);
        sum_ready  = 1'b0;
        band_valid = 8'hFF;
        tick();
        band_valid = 8'h00;
        wait_sum(n);
        check("t4_sum", sum_data, 32'd4000);
        band_valid = 8'hFF;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("t4_hold_sum", sum_data, 32'd4000);
            check("t4_hold_valid", {31'h0, sum_valid}, 32'd1);
        end
        band_valid = 8'h00;
        sum_ready  = 1'b1;
        tick();
        check("t4_released", {31'h0, sum_valid}, 32'h0);
        check("t4_collect", {24'h0, band_ready}, 32'h0000_00FF);

        // 5a: band 0 held valid, captured once only
        band_data[0 +: DW] = 16'd7;
        band_valid = 8'h01;
        tick();
        check("t5_band0_taken", {24'h0, band_ready}, 32'h0000_00FE);
        band_data[0 +: DW] = 16'd99;
        repeat (4) tick();
        for (int i = 1; i < NB; i++) band_data[i*DW +: DW] = 16'd1;
        band_valid = 8'hFF;
        tick();
        band_valid = 8'h00;
        wait_sum(n);
        check("t5_latency", 32'(n), 32'd9);
        check("t5_sum_once", sum_data, 32'd14);
        tick();

        // 5b: all muted, summing starts on the first collect cycle
        band_mask = 8'h00;
        set_all(16'd500);
        band_valid = 8'hFF;
        tick();
        band_valid = 8'h00;
        wait_sum(n);
        check("t5_muted_latency", 32'(n), 32'd8);
        check("t5_muted_sum", sum_data, 32'd0);
        tick();
        band_mask = 8'hFF;

        // 6: asynchronous reset in the fourth summing cycle
        set_all(16'd1000);
        band_valid = 8'hFF;
        tick();
        band_valid = 8'h00;
        repeat (4) tick();
        check("t6_busy_before", {31'h0, busy}, 32'd1);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_ready", {24'h0, band_ready}, 32'h0);
        check("t6_rst_valid", {31'h0, sum_valid}, 32'h0);
        check("t6_rst_data", sum_data, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("t6_ready_after", {24'h0, band_ready}, 32'h0000_00FF);
        check("t6_idle_after", {31'h0, busy}, 32'h0);
        seen = 0;
        repeat (15) begin
            tick();
            if (sum_valid) seen++;
        end
        check("t6_no_aborted_sum", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/band_sum_sequencer.md
Name: band_sum_sequencer

Overview:
Time-multiplexed scheduler for the 8-band equalizer output summation. It collects one signed 16-bit sample from each band filter through per-band valid/ready handshakes, whenever each band arrives. It then accumulates the samples one per cycle through a single shared sign-extending adder and presents the 32-bit frame sum downstream over a valid/ready handshake. A per-band mask mutes selected bands.

Parameters:
NBANDS, 8, number of equalizer bands
DATA_W, 16, band sample width, signed two's complement
ACC_W, 32, accumulator and sum width; must be >= DATA_W + clog2(NBANDS)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
band_valid  input  NBANDS  bit i = band i sample available
band_data  input  NBANDS*DATA_W  band i sample at bits [i*DATA_W +: DATA_W], signed
band_ready  output  NBANDS  bit i = block accepts band i this cycle
band_mask  input  NBANDS  bit i = 1 includes band i, 0 mutes it
sum_data  output  ACC_W  signed frame sum
sum_valid  output  1  sum_data valid
sum_ready  input  1  downstream accepts sum
busy  output  1  high in ACCUM or OUTPUT

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: band_ready = 0, sum_valid = 0, sum_data = 0, busy = 0. All capture registers, pending flags, index and accumulator are cleared. State goes to COLLECT.
- Reset asserted mid-frame discards the partial frame and any pending sum. There is no recovery of captured samples.
- The state machine has three states: COLLECT, ACCUM and OUTPUT.
- COLLECT:
  - band_ready[i] = ~pending[i].
  - A band is captured when band_valid[i] & band_ready[i] at a clock edge. That edge stores the sample and sets pending[i].
  - Each band is accepted at most once per frame. Once pending[i] is set, band_ready[i] is 0 and further valid on that band is held off.
  - A muted band (band_mask[i] = 0) counts as pending for the completion check. Its ready still follows ~pending[i], so one sample per frame is accepted and discarded.
  - Any number of bands may be captured on the same edge.
  - When every band is pending or muted, the next edge enters ACCUM. That edge also snapshots band_mask, clears the accumulator and sets index = 0.
  - If all bands are muted, ACCUM is entered on the first COLLECT cycle.
- ACCUM:
  - band_ready = 0.
  - Each edge adds sign_extend(sample[index]) to the accumulator if mask_snapshot[index] = 1, else adds 0. index then increments.
  - The edge with index = NBANDS-1 performs the last add and moves to OUTPUT.
  - This takes exactly NBANDS cycles.
- OUTPUT:
  - sum_valid = 1 and sum_data = accumulator, held stable until sum_ready.
  - The edge with sum_ready = 1 clears all pending flags and sum_valid, then returns to COLLECT.
- Latency: last capture at edge T. ACCUM occupies cycles T+1 to T+NBANDS. sum_valid is high from cycle T+NBANDS+1; this is cycle T+9 for NBANDS = 8.
- Arithmetic:
  - Sign extension replicates the sample MSB into the upper ACC_W-DATA_W bits.
  - Overflow is impossible under the ACC_W constraint. Range for the defaults is -262144 to +262136.
- Mask changes during ACCUM or OUTPUT do not affect the current frame. They apply at the next COLLECT to ACCUM transition.
- Backpressure: with sum_ready held low, the block stays in OUTPUT indefinitely with band_ready = 0.

Test Plan:
1. Simultaneous capture and accumulate: all 8 bands valid in the same cycle with values 1, 2, ..., 8, mask = 8'hFF, sum_ready = 1 -> sum_valid rises 9 cycles after the capture edge with sum_data = 36. sum_valid is 1 for one cycle, then band_ready = 8'hFF.
2. Staggered arrivals, negative values and mask: band i arrives at cycle 3*i with value -32768, mask = 8'hFF -> each band_ready[i] drops after its capture and stays low. sum_data = 32'hFFFC0000 (-262144).
3. Mask and post-snapshot change: values 100 on all bands, mask = 8'b00001111 -> sum_data = 400. Changing mask to 8'hFF during ACCUM still yields 400. The next frame with mask 8'hFF yields 800.
4. Downstream backpressure: hold sum_ready = 0 for 20 cycles after sum_valid rises -> sum_data stays stable, band_ready = 0 and band_valid is ignored. Releasing sum_ready gives a single handshake and a return to COLLECT.
5. Duplicate valid and all-muted: band 0 held valid for 5 cycles before the other bands arrive -> band 0 is captured once only. With mask = 0 and all bands captured -> sum_data = 0 after 8 ACCUM cycles.
6. Mid-frame reset: assert rst asynchronously in cycle 4 of ACCUM -> all outputs read 0 immediately. After release the block is in COLLECT with band_ready = 8'hFF and no sum is produced for the aborted frame.
